// File: rtl/version_reporter_if.sv
// version_reporter_if
// Byte-wide valid/ready stream carrying the version report line out to
// the UART transmitter.
//   m_data  : ASCII byte (source -> sink)
//   m_valid : m_data is valid (source -> sink)
//   m_ready : sink accepts the byte on a clk edge where m_valid is high
// The master modport is the byte source; the slave modport is the UART side.
interface version_reporter_if;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/version_reporter.sv
// version_pkg
// Build identification constants, rendered as hex/BCD digit pairs.
package version_pkg;
    localparam logic [7:0]  C_VER_MAJOR  = 8'h00;
    localparam logic [7:0]  C_VER_MINOR  = 8'h00;
    localparam logic [7:0]  C_VER_PATCH  = 8'h00;
    localparam logic [7:0]  C_VER_BUILD  = 8'h35;
    localparam logic [15:0] C_BLD_YEAR   = 16'h2025;
    localparam logic [7:0]  C_BLD_MONTH  = 8'h11;
    localparam logic [7:0]  C_BLD_DAY    = 8'h05;
    localparam logic [7:0]  C_BLD_HOUR   = 8'h13;
    localparam logic [7:0]  C_BLD_MINUTE = 8'h55;
    localparam logic [7:0]  C_BLD_SECOND = 8'h09;
endpackage

// version_reporter
// Serializes the build version and timestamp as one ASCII line,
// "Vmm.nn.pp.bb YYYY-MM-DD hh:mm:ss" plus CR LF (or LF only), on a
// byte-wide valid/ready stream. A line starts on a trigger pulse or when
// the optional period timer wraps.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, aborts any line in flight
//   trigger  : single-cycle request for one report line
//   m_stream : master side of the byte stream (m_data/m_valid/m_ready)
//   busy     : high while bytes of a line are being presented
//   done     : one-cycle pulse on the cycle after the last byte is accepted
module version_reporter #(
    parameter int C_PERIOD_CYCLES = 0,
    parameter bit C_EOL_CRLF      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      trigger,
    version_reporter_if.master        m_stream,
    output logic                      busy,
    output logic                      done
);
    import version_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_FIN
    } state_t;

    localparam logic [5:0] LAST_INDEX = C_EOL_CRLF ? 6'd33 : 6'd32;
    localparam int TIMER_W = (C_PERIOD_CYCLES > 0) ? $clog2(C_PERIOD_CYCLES + 1) : 1;

    state_t     state_q, state_d;
    logic [5:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pending_q, pending_d;
    logic       period_expire;
    logic       start_event;
    logic       accept;

    // 8'h37 + n equals 'A' + (n - 10) for the letter digits.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Fixed message layout; every digit pair is sent high nibble first.
    function automatic logic [7:0] msg_byte(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            6'd0:    b = 8'h56;
            6'd1:    b = hex_ascii(C_VER_MAJOR[7:4]);
            6'd2:    b = hex_ascii(C_VER_MAJOR[3:0]);
            6'd3:    b = 8'h2E;
            6'd4:    b = hex_ascii(C_VER_MINOR[7:4]);
            6'd5:    b = hex_ascii(C_VER_MINOR[3:0]);
            6'd6:    b = 8'h2E;
            6'd7:    b = hex_ascii(C_VER_PATCH[7:4]);
            6'd8:    b = hex_ascii(C_VER_PATCH[3:0]);
            6'd9:    b = 8'h2E;
            6'd10:   b = hex_ascii(C_VER_BUILD[7:4]);
            6'd11:   b = hex_ascii(C_VER_BUILD[3:0]);
            6'd12:   b = 8'h20;
            6'd13:   b = hex_ascii(C_BLD_YEAR[15:12]);
            6'd14:   b = hex_ascii(C_BLD_YEAR[11:8]);
            6'd15:   b = hex_ascii(C_BLD_YEAR[7:4]);
            6'd16:   b = hex_ascii(C_BLD_YEAR[3:0]);
            6'd17:   b = 8'h2D;
            6'd18:   b = hex_ascii(C_BLD_MONTH[7:4]);
            6'd19:   b = hex_ascii(C_BLD_MONTH[3:0]);
            6'd20:   b = 8'h2D;
            6'd21:   b = hex_ascii(C_BLD_DAY[7:4]);
            6'd22:   b = hex_ascii(C_BLD_DAY[3:0]);
            6'd23:   b = 8'h20;
            6'd24:   b = hex_ascii(C_BLD_HOUR[7:4]);
            6'd25:   b = hex_ascii(C_BLD_HOUR[3:0]);
            6'd26:   b = 8'h3A;
            6'd27:   b = hex_ascii(C_BLD_MINUTE[7:4]);
            6'd28:   b = hex_ascii(C_BLD_MINUTE[3:0]);
            6'd29:   b = 8'h3A;
            6'd30:   b = hex_ascii(C_BLD_SECOND[7:4]);
            6'd31:   b = hex_ascii(C_BLD_SECOND[3:0]);
            6'd32:   b = C_EOL_CRLF ? 8'h0D : 8'h0A;
            6'd33:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Free-running period timer; its wrap cycle is a start event.
    generate
        if (C_PERIOD_CYCLES > 0) begin : g_timer
            localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(C_PERIOD_CYCLES - 1);
            logic [TIMER_W-1:0] period_timer;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    period_timer <= '0;
                end else if (period_timer == LAST_COUNT) begin
                    period_timer <= '0;
                end else begin
                    period_timer <= period_timer + TIMER_W'(1);
                end
            end

            assign period_expire = (period_timer == LAST_COUNT);
        end else begin : g_no_timer
            assign period_expire = 1'b0;
        end
    endgenerate

    // A trigger coinciding with the timer wrap is a single event.
    assign start_event = trigger | period_expire;
    assign accept      = valid_q & m_stream.m_ready;

    // State and all outputs are registered so m_data/m_valid come straight
    // from flops; m_data only changes on acceptance or at line start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= 6'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic. Events arriving while a line is in flight are
    // folded into a one-deep pending flag; FIN restarts immediately if a
    // line is pending or a new event arrives in that very cycle.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        pending_d = pending_q;

        case (state_q)
            S_IDLE: begin
                if (start_event) begin
                    state_d = S_SEND;
                    index_d = 6'd0;
                    data_d  = msg_byte(6'd0);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SEND: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (start_event) begin
                    pending_d = 1'b1;
                end
                if (accept) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = S_FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 6'd1;
                        data_d  = msg_byte(index_q + 6'd1);
                    end
                end
            end
            S_FIN: begin
                pending_d = 1'b0;
                if (pending_q || start_event) begin
                    state_d = S_SEND;
                    index_d = 6'd0;
                    data_d  = msg_byte(6'd0);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    assign m_stream.m_data  = data_q;
    assign m_stream.m_valid = valid_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_version_reporter.sv
// tb_version_reporter
// Scoreboard bench for version_reporter. dut_a: trigger driven, CR LF.
// dut_b: 100-cycle period timer, LF only. Expected lines are pushed by
// the stimulus/model side; monitors pop and compare on every accepted byte.
module tb_version_reporter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, trigger_a, trigger_b;
    logic busy_a, done_a, busy_b, done_b;

    version_reporter_if bus_a ();
    version_reporter_if bus_b ();

    version_reporter #(.C_PERIOD_CYCLES(0), .C_EOL_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .trigger(trigger_a),
        .m_stream(bus_a), .busy(busy_a), .done(done_a)
    );

    version_reporter #(.C_PERIOD_CYCLES(100), .C_EOL_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .trigger(trigger_b),
        .m_stream(bus_b), .busy(busy_b), .done(done_b)
    );

    int checks = 0;
    int errors = 0;

    string line_text = "V00.00.00.35 2025-11-05 13:55:09";

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int  outstanding_a = 0, outstanding_b = 0;
    int  done_count_a = 0, done_count_b = 0;
    int  line_pos_a = 0;
    int  cyc_b = 0;
    bit  rand_ready_a = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, required);
        end
    endtask

    // A report line as text, followed by the configured line ending.
    task automatic push_line_a();
        for (int i = 0; i < line_text.len(); i++) exp_a.push_back(line_text[i]);
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endtask

    task automatic push_line_b();
        for (int i = 0; i < line_text.len(); i++) exp_b.push_back(line_text[i]);
        exp_b.push_back(8'h0A);
    endtask

    // One-cycle trigger pulse, sampled on the second posedge of the task.
    // For dut_a the model allows at most one line running plus one queued.
    task automatic applyStimulus(input bit to_b);
        @(posedge clk);
        #1;
        if (to_b) begin
            trigger_b = 1'b1;
        end else begin
            trigger_a = 1'b1;
            if (outstanding_a < 2) begin
                push_line_a();
                outstanding_a++;
            end
        end
        @(posedge clk);
        #1;
        trigger_a = 1'b0;
        trigger_b = 1'b0;
    endtask

    task automatic wait_idle_a(input int bound);
        int n = 0;
        while ((exp_a.size() != 0 || outstanding_a != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout_a: actual %0d bytes left required 0", exp_a.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Ready driver for dut_a: either always ready or a coin flip per cycle.
    initial begin
        bus_a.m_ready = 1'b1;
        bus_b.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_a.m_ready = rand_ready_a ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // dut_a monitor: done/busy timing, restart after done, handshake
    // stability under backpressure, and byte-by-byte scoreboard.
    bit         exp_done_a = 1'b0;
    bit         exp_restart_a = 1'b0;
    bit         stall_prev_a = 1'b0;
    logic [7:0] prev_data_a = 8'h00;
    always @(negedge clk) begin
        if (rst_a) begin
            exp_done_a    = 1'b0;
            exp_restart_a = 1'b0;
            stall_prev_a  = 1'b0;
        end else begin
            if (exp_restart_a) begin
                checkOutput("restart_valid_a", bus_a.m_valid, 1);
                checkOutput("restart_data_a", bus_a.m_data, 8'h56);
                exp_restart_a = 1'b0;
            end
            if (exp_done_a || done_a) begin
                checkOutput("done_a", done_a, exp_done_a);
                if (done_a) done_count_a++;
                if (exp_done_a) begin
                    checkOutput("busy_at_done_a", busy_a, 0);
                    outstanding_a--;
                    exp_restart_a = (outstanding_a > 0);
                    exp_done_a = 1'b0;
                end
            end
            if (stall_prev_a) begin
                checkOutput("hold_valid_a", bus_a.m_valid, 1);
                checkOutput("hold_data_a", bus_a.m_data, prev_data_a);
            end
            if (bus_a.m_valid && bus_a.m_ready) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte_a: actual 0x%0h required none", bus_a.m_data);
                end else begin
                    logic [7:0] b;
                    b = exp_a.pop_front();
                    checkOutput("byte_a", bus_a.m_data, b);
                    line_pos_a++;
                    if (b == 8'h0A) begin
                        exp_done_a = 1'b1;
                        line_pos_a = 0;
                    end
                end
            end
            stall_prev_a = bus_a.m_valid && !bus_a.m_ready;
            prev_data_a  = bus_a.m_data;
        end
    end

    // dut_b model: timer wraps every 100 cycles; a trigger in the same
    // cycle merges with the wrap into a single start event.
    always @(posedge clk) begin
        if (rst_b) begin
            cyc_b = 0;
        end else begin
            cyc_b++;
            if (((cyc_b % 100) == 0 || trigger_b) && outstanding_b < 2) begin
                push_line_b();
                outstanding_b++;
            end
        end
    end

    // dut_b monitor: lines may only begin on period boundaries.
    bit exp_done_b = 1'b0;
    bit prev_valid_b = 1'b0;
    always @(negedge clk) begin
        if (rst_b) begin
            exp_done_b   = 1'b0;
            prev_valid_b = 1'b0;
        end else begin
            if (exp_done_b || done_b) begin
                checkOutput("done_b", done_b, exp_done_b);
                if (done_b) done_count_b++;
                if (exp_done_b) begin
                    outstanding_b--;
                    exp_done_b = 1'b0;
                end
            end
            if (bus_b.m_valid && !prev_valid_b) begin
                checkOutput("period_start_b", cyc_b % 100, 0);
            end
            if (bus_b.m_valid && bus_b.m_ready) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte_b: actual 0x%0h required none", bus_b.m_data);
                end else begin
                    logic [7:0] b;
                    b = exp_b.pop_front();
                    checkOutput("byte_b", bus_b.m_data, b);
                    if (b == 8'h0A) exp_done_b = 1'b1;
                end
            end
            prev_valid_b = bus_b.m_valid;
        end
    end

    initial begin
        int n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        trigger_a = 1'b0;
        trigger_b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid_a", bus_a.m_valid, 0);
        checkOutput("reset_data_a", bus_a.m_data, 8'h00);
        checkOutput("reset_busy_a", busy_a, 0);
        checkOutput("reset_done_a", done_a, 0);
        @(posedge clk);
        #1 rst_a = 1'b0;

        // Full-rate line: 'V' the cycle after the trigger, done 34 cycles later.
        $display("[TB] full-rate line");
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("latency_valid_a", bus_a.m_valid, 1);
        checkOutput("latency_data_a", bus_a.m_data, 8'h56);
        n = 0;
        while (!done_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("line_cycles_a", n, 34);
        wait_idle_a(200);
        checkOutput("done_count_s1", done_count_a, 1);

        // Random backpressure.
        $display("[TB] random backpressure");
        rand_ready_a = 1'b1;
        done_count_a = 0;
        applyStimulus(1'b0);
        wait_idle_a(2000);
        rand_ready_a = 1'b0;
        checkOutput("done_count_s2", done_count_a, 1);

        // Three triggers inside one line give exactly two lines.
        $display("[TB] triggers during a line");
        done_count_a = 0;
        applyStimulus(1'b0);
        repeat ($urandom_range(2, 6)) @(posedge clk);
        applyStimulus(1'b0);
        repeat ($urandom_range(2, 6)) @(posedge clk);
        applyStimulus(1'b0);
        wait_idle_a(400);
        checkOutput("done_count_s3", done_count_a, 2);

        // Reset in the middle of the line, then a clean line.
        $display("[TB] reset mid-line");
        done_count_a = 0;
        applyStimulus(1'b0);
        n = 0;
        while (line_pos_a < 15 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput("reached_index_15", line_pos_a, 15);
        #2 rst_a = 1'b1;
        #1;
        checkOutput("abort_valid_a", bus_a.m_valid, 0);
        checkOutput("abort_busy_a", busy_a, 0);
        checkOutput("abort_done_a", done_a, 0);
        exp_a.delete();
        outstanding_a = 0;
        line_pos_a = 0;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        applyStimulus(1'b0);
        @(negedge clk);
        checkOutput("after_reset_data_a", bus_a.m_data, 8'h56);
        wait_idle_a(200);
        checkOutput("done_count_s4", done_count_a, 1);

        // Periodic reporting, with a trigger coinciding with the wrap at 200.
        $display("[TB] periodic reporting");
        @(posedge clk);
        #1 rst_b = 1'b0;
        @(negedge clk);
        checkOutput("reset_valid_b", bus_b.m_valid, 0);
        do begin
            @(posedge clk);
            #1;
        end while (cyc_b != 100);
        @(negedge clk);
        checkOutput("first_period_valid_b", bus_b.m_valid, 1);
        checkOutput("first_period_data_b", bus_b.m_data, 8'h56);
        do begin
            @(posedge clk);
            #1;
        end while (cyc_b != 198);
        applyStimulus(1'b1);
        do begin
            @(posedge clk);
            #1;
        end while (cyc_b != 345);
        checkOutput("done_count_b", done_count_b, 3);
        checkOutput("left_b", exp_b.size(), 0);
        checkOutput("left_a", exp_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/version_reporter.md
Name: version_reporter

Overview:
- Consumes the build-version and build-timestamp constants from version_pkg.
- Serializes them into a fixed ASCII line, `V00.00.00.35 2025-11-05 13:55:09` followed by CR LF, for the given constants.
- Output is a byte-wide valid/ready stream. It sits between version_pkg and the UART transmitter, so the board announces its build on request or periodically.

Parameters:
- C_PERIOD_CYCLES, 0, auto-report interval in clk cycles; 0 disables periodic reporting.
- C_EOL_CRLF, 1, 1 = line ends CR LF (34 bytes); 0 = LF only (33 bytes).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- trigger  input  1  single-cycle request to send one report line.
- m_data  output  8  ASCII byte to UART TX.
- m_valid  output  1  m_data valid.
- m_ready  input  1  downstream accepts byte when m_valid and m_ready are both high at a clk edge.
- busy  output  1  high from first byte presented until last byte accepted.
- done  output  1  one-cycle pulse on the cycle after the last byte is accepted.

Behaviour:
- Reset values: m_data=8'h00, m_valid=0, busy=0, done=0, byte index=0, pending=0, period timer=0.
- Clock and reset: one clock, clk. rst is asynchronous and active-high; assertion mid-line aborts immediately and returns to IDLE. No partial line resumes after reset.
- Message bytes by index (hex digits as ASCII):
  - 0: 'V'.
  - 1-2: MAJOR, 3: '.'.
  - 4-5: MINOR, 6: '.'.
  - 7-8: PATCH, 9: '.'.
  - 10-11: BUILD, 12: ' '.
  - 13-16: YEAR, 17: '-'.
  - 18-19: MONTH, 20: '-'.
  - 21-22: DAY, 23: ' '.
  - 24-25: HOUR, 26: ':'.
  - 27-28: MINUTE, 29: ':'.
  - 30-31: SECOND.
  - 32: CR (8'h0D) then 33: LF (8'h0A) when C_EOL_CRLF=1; 32: LF when C_EOL_CRLF=0.
  - Each digit pair is high nibble first.
- Nibble to ASCII: 0-9 -> 8'h30+n; A-F -> 8'h41+(n-10), uppercase. Date/time fields are BCD, so they render as decimal digits.
- FSM states:
  - IDLE: m_valid=0. On start event -> SEND with index=0, busy=1.
  - SEND: m_valid=1, m_data=byte[index]. On accept: if index is last -> FIN, else index+1.
  - FIN: one cycle; done=1, busy=0, m_valid=0. Then -> SEND (index 0) if pending, else IDLE; pending cleared.
- Start event = trigger, or period timer expiry.
- Latency: trigger at cycle T gives m_valid=1 with 'V' at cycle T+1 (registered).
- Handshake rules:
  - m_data and m_valid are registered.
  - m_data is held stable while m_valid && !m_ready.
  - m_valid never drops before acceptance.
  - Back-to-back bytes are sent at full rate when m_ready is held high.
- Trigger while busy or in FIN sets pending (one deep); extra triggers are absorbed. At most one queued line.
- Period timer (C_PERIOD_CYCLES>0):
  - Free-running counter 0..C_PERIOD_CYCLES-1.
  - Expiry on wrap is a start event; it is treated like trigger, so it sets pending if busy.
  - Trigger and expiry in the same cycle count as one event.
  - Width is $clog2(C_PERIOD_CYCLES+1).
- Index width is 6 bits; no wrap beyond the last index.

Test Plan:
- Reset, then 1-cycle trigger, m_ready=1 constant:
  - Exactly 34 bytes are accepted on consecutive cycles: 56 30 30 2E 30 30 2E 30 30 2E 33 35 20 32 30 32 35 2D 31 31 2D 30 35 20 31 33 3A 35 35 3A 30 39 0D 0A.
  - done pulses once, one cycle after the 0A is accepted; busy is low on that same cycle.
- Random m_ready backpressure (about 50%): the same 34-byte sequence arrives, and m_data never changes while m_valid=1 and m_ready=0.
- Trigger pulsed 3 times during a line: exactly 2 lines total, the second starting the cycle after done, with 2 done pulses.
- rst asserted at byte index 15: m_valid, busy and done are 0 immediately. A later trigger produces a full line starting at 'V'.
- C_PERIOD_CYCLES=100, C_EOL_CRLF=0, m_ready=1:
  - A line starts every 100 cycles, first 'V' at cycle 101 after reset release.
  - Each line is 33 bytes ending in 0A.
  - No trigger input is needed.
- Trigger coincident with timer expiry while idle: exactly one line results, with no pending repeat.
